// File: rtl/dma_rd_thread.sv
// dma_rd_thread: one DMA read thread. Splits a (base, lines) command into
// line-aligned tagged read requests, matches returning responses to their
// line index by tag, and pulses done when every line has come back.
// Optional build macro DMA_RD_THREAD_PERF_EN adds perf_cycles/perf_stall.

package dma_rd_thread_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TID_W  = 8;
    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;

    typedef struct packed {
        logic [1:0]        opcode;
        logic [ADDR_W-1:0] addr;
        logic [TID_W-1:0]  tid;
        logic [7:0]        len;
    } dma_req_t;

    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic [DATA_W-1:0] data;
        logic [1:0]        status;
    } dma_rsp_t;
endpackage

module dma_rd_thread
    import dma_rd_thread_pkg::*;
#(
    parameter int unsigned THREAD_ID       = 0,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned LINE_BYTES      = 32,
    parameter int unsigned LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_lines,
    output logic             req_valid,
    input  logic             req_ready,
    output dma_req_t         req,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  dma_rsp_t         resp,
    output logic             rd_valid,
    input  logic             rd_ready,
    output dma_rsp_t         rd_info,
    output logic [LEN_W-1:0] rd_idx,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef DMA_RD_THREAD_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
`endif
);

    localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned NTAG  = 1 << TAG_W;
    localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q;
    logic [LEN_W-1:0]   lines_q, issued_q, returned_q;
    logic [NTAG-1:0]    busy_map_q;
    logic [LEN_W-1:0]   idx_tbl_q [NTAG];
    logic               hold_vld_q;
    logic [TAG_W-1:0]   hold_tag_q;
    logic               err_q;

    logic               free_any;
    logic [TAG_W-1:0]   free_tag;
    logic [TAG_W-1:0]   sel_tag;
    logic               alloc_ok;
    logic [3:0]         rsp_tag;
    logic [TAG_W-1:0]   rsp_slot;
    logic               rsp_ok, rsp_fire, rsp_bad;
    logic               cmd_fire, req_fire;
    logic [NTAG-1:0]    alloc_vec, free_vec;

    // Lowest-numbered free tag from the registered bitmap
    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
            if (!busy_map_q[i]) begin
                free_any = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    // A request left waiting keeps its tag so the payload stays stable
    assign sel_tag  = hold_vld_q ? hold_tag_q : free_tag;
    assign alloc_ok = hold_vld_q | free_any;

    // Response classification and pass-through to the consumer
    assign rsp_tag    = resp.tid[3:0];
    assign rsp_slot   = rsp_tag[TAG_W-1:0];
    assign rsp_ok     = (state_q != S_IDLE) && (resp.tid[6:4] == 3'(THREAD_ID)) &&
                        (32'(rsp_tag) < MAX_OUTSTANDING) && busy_map_q[rsp_slot];
    assign rd_valid   = resp_valid & rsp_ok;
    assign resp_ready = rd_ready | (resp_valid & ~rsp_ok);
    assign rd_info    = resp;
    assign rd_idx     = idx_tbl_q[rsp_slot];
    assign rsp_fire   = resp_valid & rsp_ok & rd_ready;
    assign rsp_bad    = resp_valid & ~rsp_ok;

    assign cmd_fire  = cmd_valid & (state_q == S_IDLE);
    assign req_fire  = req_valid & req_ready;
    assign alloc_vec = req_fire ? (NTAG'(1) << sel_tag) : '0;
    assign free_vec  = rsp_fire ? (NTAG'(1) << rsp_slot) : '0;
    assign err       = err_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: ISSUE/DRAIN look ahead at the final handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cmd_valid) state_d = (cmd_lines == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (req_fire && ((issued_q + LEN_W'(1)) == lines_q)) state_d = S_DRAIN;
            S_DRAIN: if (rsp_fire && ((returned_q + LEN_W'(1)) == lines_q)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and the request payload
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        req_valid = (state_q == S_ISSUE) && (issued_q < lines_q) && alloc_ok;
        req       = '0;
        if (req_valid) begin
            req.opcode = OP_RD;
            req.addr   = addr_q;
            req.tid    = {1'b0, 3'(THREAD_ID), 4'(sel_tag)};
        end
    end

    // Command latch, issue/return counters, tag bitmap and line-index table
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            lines_q    <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            busy_map_q <= '0;
            hold_vld_q <= 1'b0;
            hold_tag_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(NTAG); i++) idx_tbl_q[i] <= '0;
        end else begin
            if (cmd_fire) begin
                addr_q     <= cmd_addr & ALIGN_MASK;
                lines_q    <= cmd_lines;
                issued_q   <= '0;
                returned_q <= '0;
            end
            if (req_fire) begin
                addr_q             <= addr_q + 32'(LINE_BYTES);
                issued_q           <= issued_q + LEN_W'(1);
                idx_tbl_q[sel_tag] <= issued_q;
            end
            if (rsp_fire) returned_q <= returned_q + LEN_W'(1);
            busy_map_q <= (busy_map_q | alloc_vec) & ~free_vec;
            hold_vld_q <= req_valid & ~req_ready;
            hold_tag_q <= sel_tag;
            if (rsp_bad)       err_q <= 1'b1;
            else if (cmd_fire) err_q <= 1'b0;
        end
    end

`ifdef DMA_RD_THREAD_PERF_EN
    logic stall_c;
    assign stall_c = (state_q == S_ISSUE) && ((req_valid && !req_ready) || !alloc_ok);

    // Saturating busy-cycle and issue-stall counters for the last command
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (cmd_fire) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1))   perf_cycles <= perf_cycles + 32'd1;
            if (stall_c && (perf_stall != '1)) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_rd_thread.sv
// tb_dma_rd_thread: randomized bench with a transaction-level reference model
// (outstanding-tag set, expected line addresses, completion bookkeeping).
`timescale 1ns/1ps
module tb_dma_rd_thread;
    import dma_rd_thread_pkg::*;

    localparam int unsigned TID_THR = 2;
    localparam int unsigned MAXO    = 8;
    localparam int unsigned LB      = 32;
    localparam int unsigned LW      = 16;
    localparam int unsigned BUDGET  = 3000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready;
    logic [31:0]   cmd_addr;
    logic [LW-1:0] cmd_lines;
    logic          req_valid, req_ready;
    dma_req_t      req;
    logic          resp_valid, resp_ready;
    dma_rsp_t      resp;
    logic          rd_valid, rd_ready;
    dma_rsp_t      rd_info;
    logic [LW-1:0] rd_idx;
    logic          busy, done, err;
`ifdef DMA_RD_THREAD_PERF_EN
    logic [31:0]   perf_cycles, perf_stall;
`endif

    dma_rd_thread #(
        .THREAD_ID(TID_THR), .MAX_OUTSTANDING(MAXO), .LINE_BYTES(LB), .LEN_W(LW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_lines(cmd_lines),
        .req_valid(req_valid), .req_ready(req_ready), .req(req),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_info(rd_info), .rd_idx(rd_idx),
        .busy(busy), .done(done), .err(err)
`ifdef DMA_RD_THREAD_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_active, m_done_due, m_err, m_hold_vld;
    int          m_hold_tag;
    logic [31:0] m_base;
    int          m_n, m_issued, m_returned;
    bit          m_bsy [MAXO];
    int          m_idx [MAXO];

    // Values driven in the next cycle
    bit          d_cmd_valid;
    logic [31:0] d_cmd_addr;
    int          d_cmd_lines;
    bit          d_req_ready, d_resp_valid, d_rd_ready;
    dma_rsp_t    d_resp;

    function automatic int lowest_free();
        for (int i = 0; i < int'(MAXO); i++) if (!m_bsy[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_active = 0; m_done_due = 0; m_err = 0; m_hold_vld = 0; m_hold_tag = 0;
        m_base = '0; m_n = 0; m_issued = 0; m_returned = 0;
        for (int i = 0; i < int'(MAXO); i++) begin m_bsy[i] = 0; m_idx[i] = 0; end
    endfunction

    // mode 0: any outstanding tag; 1: oldest line first; 2: newest line first.
    // Modes 1 and 2 wait until every line has been issued.
    function automatic int pick_tag(input int mode);
        int cand [$];
        int best;
        for (int i = 0; i < int'(MAXO); i++) if (m_bsy[i]) cand.push_back(i);
        if (cand.size() == 0) return -1;
        if (mode == 0) return cand[$urandom_range(cand.size() - 1)];
        if (m_issued < m_n) return -1;
        best = cand[0];
        foreach (cand[k]) begin
            if (mode == 1 && m_idx[cand[k]] < m_idx[best]) best = cand[k];
            if (mode == 2 && m_idx[cand[k]] > m_idx[best]) best = cand[k];
        end
        return best;
    endfunction

    // One clock: drive, sample mid-cycle, compare against the model, advance it
    task automatic step();
        int          exp_free, exp_tag, rt;
        bit          exp_rv, rok, done_next;
        dma_req_t    er;
        @(posedge clk); #1;
        cmd_valid  = d_cmd_valid;
        cmd_addr   = d_cmd_addr;
        cmd_lines  = LW'(d_cmd_lines);
        req_ready  = d_req_ready;
        resp_valid = d_resp_valid;
        resp       = d_resp;
        rd_ready   = d_rd_ready;
        @(negedge clk);
        exp_free = lowest_free();
        exp_rv   = m_active && (m_issued < m_n) && (m_hold_vld || exp_free >= 0);
        exp_tag  = m_hold_vld ? m_hold_tag : exp_free;
        check("cmd_ready", 128'(cmd_ready), 128'(!m_active && !m_done_due));
        check("busy", 128'(busy), 128'(m_active));
        check("done", 128'(done), 128'(m_done_due));
        check("err", 128'(err), 128'(m_err));
        check("req_valid", 128'(req_valid), 128'(exp_rv));
        if (exp_rv) begin
            er        = '0;
            er.opcode = OP_RD;
            er.addr   = m_base + 32'(m_issued * int'(LB));
            er.tid    = {1'b0, 3'(TID_THR), 4'(exp_tag)};
            check("req", 128'(req), 128'(er));
        end
        rt  = int'(d_resp.tid[3:0]);
        rok = 0;
        if (d_resp_valid) begin
            rok = m_active && (d_resp.tid[6:4] == 3'(TID_THR)) && (rt < int'(MAXO)) && m_bsy[rt % int'(MAXO)];
            check("rd_valid", 128'(rd_valid), 128'(rok));
            check("resp_ready", 128'(resp_ready), 128'(rok ? d_rd_ready : 1'b1));
            if (rok) begin
                check("rd_idx", 128'(rd_idx), 128'(m_idx[rt]));
                check("rd_info", 128'(rd_info), 128'(d_resp));
            end
        end
        done_next = 0;
        if (d_cmd_valid && !m_active && !m_done_due) begin
            m_err = 0;
            m_base = d_cmd_addr & ~(32'(LB) - 32'd1);
            m_n = d_cmd_lines; m_issued = 0; m_returned = 0;
            if (d_cmd_lines == 0) done_next = 1; else m_active = 1;
        end
        if (d_resp_valid) begin
            if (!rok) m_err = 1;
            else if (d_rd_ready) begin
                m_bsy[rt] = 0;
                m_returned++;
                if (m_returned == m_n) begin m_active = 0; done_next = 1; end
            end
        end
        if (exp_rv && d_req_ready) begin
            m_bsy[exp_tag] = 1; m_idx[exp_tag] = m_issued; m_issued++; m_hold_vld = 0;
        end else if (exp_rv) begin
            m_hold_vld = 1; m_hold_tag = exp_tag;
        end else m_hold_vld = 0;
        m_done_due = done_next;
    endtask

    task automatic idle_drive();
        d_cmd_valid = 0; d_cmd_addr = '0; d_cmd_lines = 0;
        d_req_ready = 0; d_resp_valid = 0; d_resp = '0; d_rd_ready = 0;
    endtask

    // Run one command to completion under a given response policy
    task automatic run_cmd(input logic [31:0] addr, input int n, input int mode,
                           input int rr_pct, input int rsp_pct, input int hold,
                           input int force_tag, input int bad_pct);
        int  cyc, t, kind;
        bit  forced;
        d_cmd_valid = 1; d_cmd_addr = addr; d_cmd_lines = n;
        d_req_ready = 1; d_resp_valid = 0; d_rd_ready = 1;
        step();
        d_cmd_valid = 0;
        cyc = 0; forced = 0;
        while ((m_active || m_done_due) && cyc < int'(BUDGET)) begin
            d_req_ready  = ($urandom_range(99) < rr_pct);
            d_rd_ready   = (rsp_pct >= 100) ? 1'b1 : ($urandom_range(99) < 75);
            d_resp_valid = 0;
            d_resp.tid   = '0;
            d_resp.data  = {$urandom, $urandom};
            d_resp.status = 2'($urandom);
            t = -1;
            if (cyc >= hold) begin
                if (!forced && force_tag >= 0 && m_bsy[force_tag]) begin
                    t = force_tag; forced = 1;
                end else if ($urandom_range(99) < rsp_pct) t = pick_tag(mode);
            end
            if (t >= 0) begin
                d_resp_valid = 1;
                d_resp.tid = {1'b0, 3'(TID_THR), 4'(t)};
            end else if (m_active && $urandom_range(99) < bad_pct) begin
                d_resp_valid = 1;
                kind = int'($urandom_range(2));
                if (kind == 1)                             d_resp.tid = {1'b0, 3'(TID_THR), 4'(8 + $urandom_range(7))};
                else if (kind == 2 && lowest_free() >= 0)  d_resp.tid = {1'b0, 3'(TID_THR), 4'(lowest_free())};
                else                                       d_resp.tid = {1'b0, 3'd3, 4'($urandom_range(7))};
            end
            step();
            cyc++;
        end
        if (cyc >= int'(BUDGET)) check("cmd_timeout", 128'(1), 128'(0));
        idle_drive();
        step();
    endtask

    initial begin
        model_reset();
        idle_drive();
        cmd_valid = 0; cmd_addr = '0; cmd_lines = '0; req_ready = 0;
        resp_valid = 0; resp = '0; rd_ready = 0;
        rstn = 0;
        #12;
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_req_valid", 128'(req_valid), 128'(0));
        check("rst_req", 128'(req), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_resp_ready", 128'(resp_ready), 128'(0));
        @(negedge clk); rstn = 1;

        // In-order, back-to-back issue with misaligned base
        run_cmd(32'h8000_0010, 3, 1, 100, 100, 0, -1, 0);
        // Withheld responses fill all tags; tag 5 returns first and is reused
        run_cmd(32'h0000_1000, 20, 0, 100, 100, 12, 5, 0);
        // Reverse-order return
        run_cmd(32'h0000_0040, 3, 2, 100, 100, 0, -1, 0);
        // Foreign / stale responses mixed in while draining
        run_cmd(32'h0000_2000, 4, 2, 100, 50, 0, -1, 60);
        // Zero-line command and address wrap
        run_cmd(32'h0000_0123, 0, 0, 100, 100, 0, -1, 0);
        run_cmd(32'hFFFF_FFE0, 2, 0, 100, 100, 0, -1, 0);

        // Reset with four lines outstanding, then a late response
        d_cmd_valid = 1; d_cmd_addr = 32'h0000_3000; d_cmd_lines = 10;
        d_req_ready = 1; d_resp_valid = 0; d_rd_ready = 0;
        step();
        d_cmd_valid = 0;
        repeat (4) step();
        #2 rstn = 0;
        #1;
        check("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("mid_rst_req_valid", 128'(req_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        check("mid_rst_err", 128'(err), 128'(0));
        check("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
        model_reset();
        @(negedge clk); rstn = 1;
        idle_drive();
        d_resp_valid = 1; d_resp.tid = 8'h20; d_resp.data = 64'hDEAD_BEEF; d_rd_ready = 1;
        step();
        idle_drive();
        step();
        step();

        // Randomized commands
        for (int k = 0; k < 25; k++) begin
            run_cmd({$urandom}, int'($urandom_range(24)), 0,
                    int'($urandom_range(100, 40)), int'($urandom_range(90, 30)),
                    0, -1, 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
